dct_transpose_8x8: RTL and testbench
====================================

Name: dct_transpose_8x8

Overview:
- Ping-pong 8x8 transpose buffer between the row-pass 1-D DCT and the column-pass 1-D DCT of the 2-D 8x8 DCT.
- Accepts eight 8-word row vectors per block (row-DCT results) and emits eight 8-word column vectors of the same block.
- Uses two banks, so one block fills while the previous block drains; sustains 1 vector/cycle in and out.
- Words are opaque DATA_WIDTH values; no arithmetic is performed.

Parameters:
- DATA_WIDTH, 32, width of one coefficient word.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  row_in holds a valid row vector.
- in_ready  output  1  block can accept a row this cycle.
- row_in  input  DATA_WIDTH*8  row r of current block; word j at [j*DATA_WIDTH +: DATA_WIDTH] = element (r,j).
- out_valid  output  1  col_out holds a valid column vector.
- out_ready  input  1  downstream accepts col_out this cycle.
- col_out  output  DATA_WIDTH*8  column c; word k at [k*DATA_WIDTH +: DATA_WIDTH] = element (k,c).
- out_last  output  1  high with out_valid on column 7 of a block.

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous, active-low on reset_n.
- Reset values: both bank-full flags 0, wr_bank=0, wr_row=0, rd_bank=0, rd_col=0, so out_valid=0, out_last=0, col_out=0, in_ready=1. Bank storage is not reset.
- Reset mid-block discards all partial and full blocks. The first row after reset is row 0 of bank 0.
- Storage: mem[bank 0..1][row 0..7][col 0..7], each DATA_WIDTH wide, flop-based.
- Write side:
  - in_ready = !full[wr_bank].
  - Accept = in_valid && in_ready. On accept, mem[wr_bank][wr_row][j] <= row_in word j for all j, and wr_row increments.
  - On accept with wr_row==7: full[wr_bank] <= 1, wr_row <= 0, wr_bank toggles.
  - in_valid while !in_ready: no state change. Producer must hold data stable.
- Read side:
  - out_valid = full[rd_bank].
  - col_out word k = mem[rd_bank][k][rd_col] when out_valid, else all zeros.
  - out_last = out_valid && rd_col==7.
  - Transfer = out_valid && out_ready. On transfer, rd_col increments.
  - On transfer with rd_col==7: full[rd_bank] <= 0, rd_col <= 0, rd_bank toggles.
  - out_ready without out_valid: no effect. out_valid with !out_ready: outputs held stable.
- Latency: the edge that accepts row 7 makes column 0 valid in the following cycle (1 cycle from last row to first column).
- Throughput: with continuous in_valid and out_ready, steady state is 8 rows in and 8 columns out per 8 cycles, in_ready stays 1, no bubbles after the first block.
- Simultaneous events:
  - Write completing bank A and read completing bank B in the same cycle is legal. full[A] sets and full[B] clears independently.
  - Writing into a bank being drained is impossible, because the bank stays full until its last column transfers.
- Both banks full: in_ready=0 until rd_col 7 of rd_bank transfers. in_ready rises the cycle after that transfer.
- Both banks empty: out_valid=0, col_out=0.
- Pointers are 3-bit and wrap 7->0. Bank pointer is 1-bit and toggles.

Decomposition:
- Shared package dct_pkg:
  - DCT_N=8, DCT_LOG2N=3, DCT_BANKS=2.
  - Word and vector width helpers derived from DATA_WIDTH (also used by dct_1d_8x1 and dct_8muladd).
- One natural sub-module, dct_tp_bank: one 8x8 word bank with a row write port (we, row index, 8-word row) and a combinational column read (column index -> 8-word column).
  - Instantiated twice.
  - Top level holds pointers, full flags, handshake and output mux.

Test Plan:
- Single block: rows r=0..7 with element (r,c)=16*r+c, out_ready=1 -> out_valid rises cycle after row 7. Column c outputs words {c, 16+c, ..., 112+c}. out_last only on column 7 (words 7,23,...,119).
- Back-to-back streaming: 4 blocks (block b adds 256*b), in_valid and out_ready held 1 -> in_ready never drops after reset. 32 columns out in order, each correctly transposed, no gaps after the first.
- Backpressure: out_ready=0 while 16 rows are offered -> in_ready=0 after the 16th row. The 17th row is held off. out_valid=1 with column 0 of block 0 stable. Raising out_ready drains block 0 and in_ready returns 1 after its column 7.
- Input bubbles: in_valid toggled 1/0 each cycle over 8 rows -> exactly 8 rows stored. Output identical to the single-block case.
- Random out_ready stalls (50%) over 3 blocks -> col_out/out_last stable while stalled. All 24 columns match the scoreboard.
- Reset mid-block: assert reset_n=0 after 5 rows of block 0 -> immediately out_valid=0, col_out=0, in_ready=1. After release, a fresh 8-row block outputs only new data.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared constants and width helpers for the 8x8 DCT datapath blocks.
package dct_pkg;

  localparam int unsigned DCT_N     = 8;
  localparam int unsigned DCT_LOG2N = 3;
  localparam int unsigned DCT_BANKS = 2;

  typedef logic [DCT_LOG2N-1:0] dct_idx_t;

  function automatic int unsigned dct_word_width(input int unsigned data_width);
    return data_width;
  endfunction

  function automatic int unsigned dct_vec_width(input int unsigned data_width);
    return data_width * DCT_N;
  endfunction

endpackage

// File: rtl/dct_transpose_8x8_if.sv
// Row-in / column-out streaming handshake of the 8x8 transpose buffer.
interface dct_transpose_8x8_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  import dct_pkg::*;

  logic                                    in_valid;
  logic                                    in_ready;
  logic [dct_vec_width(DATA_WIDTH)-1:0]    row_in;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [dct_vec_width(DATA_WIDTH)-1:0]    col_out;
  logic                                    out_last;

  modport slave (
    input  in_valid, row_in, out_ready,
    output in_ready, out_valid, col_out, out_last
  );

  modport master (
    output in_valid, row_in, out_ready,
    input  in_ready, out_valid, col_out, out_last
  );

endinterface

// File: rtl/dct_tp_bank.sv
// One 8x8 word bank: full-row write port, combinational full-column read port.
module dct_tp_bank
  import dct_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                 clk_i,
  input  logic                                 we_i,
  input  dct_idx_t                             row_idx_i,
  input  logic [dct_vec_width(DATA_WIDTH)-1:0] row_i,
  input  dct_idx_t                             col_idx_i,
  output logic [dct_vec_width(DATA_WIDTH)-1:0] col_o
);

  logic [DATA_WIDTH-1:0] mem_q [DCT_N][DCT_N];
  logic [DATA_WIDTH-1:0] mem_d [DCT_N][DCT_N];

  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      for (int j = 0; j < DCT_N; j++) begin
        mem_d[row_idx_i][j] = row_i[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Storage is deliberately not reset; the full flags in the top qualify it.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_comb begin
    col_o = '0;
    for (int k = 0; k < DCT_N; k++) begin
      col_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k][col_idx_i];
    end
  end

endmodule

// File: rtl/dct_transpose_8x8.sv
// Ping-pong 8x8 transpose buffer: one bank fills with rows while the other drains as columns.
module dct_transpose_8x8
  import dct_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  dct_transpose_8x8_if.slave  bus
);

  localparam int unsigned VecW = dct_vec_width(DATA_WIDTH);
  localparam dct_idx_t    IdxMax = dct_idx_t'(DCT_N - 1);

  logic [DCT_BANKS-1:0] full_q, full_d;
  logic                 wr_bank_q, wr_bank_d;
  dct_idx_t             wr_row_q, wr_row_d;
  logic                 rd_bank_q, rd_bank_d;
  dct_idx_t             rd_col_q, rd_col_d;

  logic                 accept, xfer, out_valid;
  logic [VecW-1:0]      bank_col [DCT_BANKS];

  assign out_valid = full_q[rd_bank_q];
  assign accept    = bus.in_valid && !full_q[wr_bank_q];
  assign xfer      = out_valid && bus.out_ready;

  for (genvar b = 0; b < DCT_BANKS; b++) begin : g_bank
    dct_tp_bank #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk_i     (clk),
      .we_i      (accept && (wr_bank_q == 1'(b))),
      .row_idx_i (wr_row_q),
      .row_i     (bus.row_in),
      .col_idx_i (rd_col_q),
      .col_o     (bank_col[b])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_row_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_col_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_row_q  <= wr_row_d;
      rd_bank_q <= rd_bank_d;
      rd_col_q  <= rd_col_d;
    end
  end

  // Set and clear never target the same bank: a full bank blocks writes until drained.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    rd_bank_d = rd_bank_q;
    rd_col_d  = rd_col_q;
    if (accept) begin
      wr_row_d = wr_row_q + 3'd1;
      if (wr_row_q == IdxMax) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (xfer) begin
      rd_col_d = rd_col_q + 3'd1;
      if (rd_col_q == IdxMax) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  always_comb begin
    bus.in_ready  = !full_q[wr_bank_q];
    bus.out_valid = out_valid;
    bus.out_last  = out_valid && (rd_col_q == IdxMax);
    bus.col_out   = out_valid ? bank_col[rd_bank_q] : '0;
  end

endmodule

// File: tb/tb_dct_transpose_8x8.sv
// Scoreboard bench for the 8x8 ping-pong transpose buffer.
module tb_dct_transpose_8x8;

  localparam int DW = 32;
  localparam int VW = DW * 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dct_transpose_8x8_if #(.DATA_WIDTH(DW)) bus ();

  dct_transpose_8x8 #(.DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [VW-1:0] col;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   rdy_mode = 1;
  int   cyc = 0;
  int   xfer_cnt = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;
  logic [DW-1:0] blk [8][8];

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // 0: stalled, 1: always ready, 2: random 50% ready
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic [VW-1:0] held_col;
  logic          held_last;
  bit            stalled = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        check("stall_valid", VW'(bus.out_valid), VW'(1));
        check("stall_col", bus.col_out, held_col);
        check("stall_last", VW'(bus.out_last), VW'(held_last));
      end
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          exp_t e;
          stalled = 0;
          if (sb.size() == 0) begin
            check("unexpected_col", VW'(bus.out_valid), VW'(0));
          end else begin
            e = sb.pop_front();
            check("col", bus.col_out, e.col);
            check("last", VW'(bus.out_last), VW'(e.last));
          end
          if (xfer_cnt == 0) first_cyc = cyc;
          last_cyc = cyc;
          xfer_cnt++;
        end else begin
          stalled   = 1;
          held_col  = bus.col_out;
          held_last = bus.out_last;
        end
      end else begin
        stalled = 0;
        check("idle_col", bus.col_out, '0);
        check("idle_last", VW'(bus.out_last), VW'(0));
      end
    end
  end

  function automatic void fill_pattern(input int b);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) blk[r][c] = DW'(16 * r + c + 256 * b);
  endfunction

  function automatic void fill_random();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) blk[r][c] = $urandom;
  endfunction

  function automatic logic [VW-1:0] row_vec(input int r);
    logic [VW-1:0] v;
    for (int j = 0; j < 8; j++) v[j*DW +: DW] = blk[r][j];
    return v;
  endfunction

  task automatic send_row(input logic [VW-1:0] v, output int waits, output bit ok);
    bus.in_valid = 1'b1;
    bus.row_in   = v;
    ok    = 0;
    waits = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
      else waits++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_block(input bit bubbles, input bit push, output int waits_total);
    int w;
    bit ok;
    waits_total = 0;
    for (int r = 0; r < 8; r++) begin
      if (bubbles && r > 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_row(row_vec(r), w, ok);
      waits_total += w;
      if (!ok) check("row_accept_timeout", VW'(ok), VW'(1));
    end
    bus.in_valid = 1'b0;
    if (push) begin
      for (int c = 0; c < 8; c++) begin
        exp_t e;
        for (int k = 0; k < 8; k++) e.col[k*DW +: DW] = blk[k][c];
        e.last = (c == 7);
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 500 && sb.size() != 0; t++) @(negedge clk);
    check(name, VW'(sb.size()), VW'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int wsum;
    bit ok;
    bit seen;
    bus.in_valid = 1'b0;
    bus.row_in   = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    @(negedge clk);
    check("rst_in_ready", VW'(bus.in_ready), VW'(1));
    check("rst_out_valid", VW'(bus.out_valid), VW'(0));
    check("rst_col_out", bus.col_out, '0);
    check("rst_out_last", VW'(bus.out_last), VW'(0));
    @(posedge clk);
    #1;

    // Single block, latency of one cycle from row 7 to column 0
    rdy_mode = 1;
    fill_pattern(0);
    send_block(0, 1, w);
    @(negedge clk);
    check("latency_valid", VW'(bus.out_valid), VW'(1));
    drain("single_drain");

    // Back-to-back streaming of four blocks
    xfer_cnt = 0;
    wsum = 0;
    for (int b = 0; b < 4; b++) begin
      fill_pattern(b);
      send_block(0, 1, w);
      wsum += w;
    end
    drain("stream_drain");
    check("stream_in_stalls", VW'(wsum), VW'(0));
    check("stream_cols", VW'(xfer_cnt), VW'(32));
    check("stream_gapless", VW'(last_cyc - first_cyc), VW'(31));

    // Backpressure: both banks fill, 17th row held off
    rdy_mode = 0;
    @(posedge clk);
    #1;
    fill_pattern(10);
    send_block(0, 1, w);
    fill_pattern(11);
    send_block(0, 1, w);
    @(negedge clk);
    check("bp_in_ready_low", VW'(bus.in_ready), VW'(0));
    check("bp_out_valid", VW'(bus.out_valid), VW'(1));
    fork
      begin
        fill_pattern(12);
        send_block(0, 1, w);
      end
      begin
        repeat (4) begin
          @(negedge clk);
          check("bp_held_off", VW'(bus.in_ready), VW'(0));
        end
        rdy_mode = 1;
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
          @(negedge clk);
          if (bus.out_valid && bus.out_ready && bus.out_last) seen = 1;
        end
        check("bp_last_seen", VW'(seen), VW'(1));
        @(negedge clk);
        check("bp_ready_return", VW'(bus.in_ready), VW'(1));
      end
    join
    drain("bp_drain");

    // Input bubbles
    fill_pattern(0);
    send_block(1, 1, w);
    drain("bubble_drain");

    // Random output stalls over three random blocks
    rdy_mode = 2;
    for (int b = 0; b < 3; b++) begin
      fill_random();
      send_block(0, 1, w);
    end
    drain("random_drain");
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Reset with one full bank and a partial block in flight
    fill_random();
    send_block(0, 0, w);
    fill_random();
    for (int r = 0; r < 5; r++) send_row(row_vec(r), w, ok);
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", VW'(bus.out_valid), VW'(0));
    check("mid_rst_col_out", bus.col_out, '0);
    check("mid_rst_in_ready", VW'(bus.in_ready), VW'(1));
    check("mid_rst_out_last", VW'(bus.out_last), VW'(0));
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    rdy_mode = 1;
    fill_pattern(5);
    send_block(0, 1, w);
    drain("post_rst_drain");
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
